// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: decodes Op/Funct into datapath controls, with
// MemReady wait states and a watchdog. Optional macro BNE_EN adds bne.
module mips_multicycle_ctrl #(
  parameter int unsigned MAX_WAIT      = 15,
  parameter int unsigned ALUCTRL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [5:0]               Op,
  input  logic [5:0]               Funct,
  input  logic                     Zero,
  input  logic                     MemReady,
  output logic                     PCWrite,
  output logic [1:0]               PCSrc,
  output logic                     IorD,
  output logic                     MemWrite,
  output logic                     IRWrite,
  output logic                     RegDst,
  output logic                     MemtoReg,
  output logic                     RegWrite,
  output logic                     ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [ALUCTRL_WIDTH-1:0] ALUControl,
  output logic                     IllegalOp,
  output logic                     MemTimeout,
  output logic [3:0]               State
);

  localparam int unsigned WD_W = 8;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q;
  logic            wd_inc;
  logic            wd_hit;
  logic [2:0]      alu_op;

`ifdef BNE_EN
  logic bne_q;
`endif

  // Watchdog expiry condition shared by the three memory-wait states
  assign wd_hit = (wd_q == WD_W'(MAX_WAIT)) && !MemReady;

  // State register, wait-cycle counter and bne flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || MemTimeout)
        wd_q <= '0;
      else if (wd_inc)
        wd_q <= wd_q + WD_W'(1);
    end
  end

`ifdef BNE_EN
  always_ff @(posedge clk) begin
    if (reset)
      bne_q <= 1'b0;
    else if (state_q == S_DECODE)
      bne_q <= (Op == OP_BNE);
  end
`endif

  // Next-state and Moore control decode (MemReady gates the memory states)
  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    PCSrc      = 2'b00;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    alu_op     = 3'b000;
    IllegalOp  = 1'b0;
    MemTimeout = 1'b0;
    wd_inc     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        alu_op  = ALU_ADD;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (wd_hit) begin
          MemTimeout = 1'b1;
          state_d    = S_FETCH;
        end else begin
          wd_inc = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        alu_op  = ALU_ADD;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            IllegalOp = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu_op  = ALU_ADD;
        state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        IorD = 1'b1;
        if (MemReady) begin
          state_d = S_MEMWB;
        end else if (wd_hit) begin
          MemTimeout = 1'b1;
          state_d    = S_FETCH;
        end else begin
          wd_inc = 1'b1;
        end
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD = 1'b1;
        if (MemReady) begin
          MemWrite = 1'b1;
          state_d  = S_FETCH;
        end else if (wd_hit) begin
          MemTimeout = 1'b1;
          state_d    = S_FETCH;
        end else begin
          MemWrite = 1'b1;
          wd_inc   = 1'b1;
        end
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        case (Funct)
          6'b100000: alu_op = ALU_ADD;
          6'b100010: alu_op = ALU_SUB;
          6'b100100: alu_op = ALU_AND;
          6'b100101: alu_op = ALU_OR;
          6'b101010: alu_op = ALU_SLT;
          default:   alu_op = ALU_ADD;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALU_SUB;
        PCSrc   = 2'b01;
`ifdef BNE_EN
        PCWrite = Zero ^ bne_q;
`else
        PCWrite = Zero;
`endif
        state_d = S_FETCH;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu_op  = ALU_ADD;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign ALUControl = ALUCTRL_WIDTH'(alu_op);
  assign State      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction expected cycle sequences
// built from the control table, replayed against the DUT with random MemReady/Zero.
module tb_mips_multicycle_ctrl;

  localparam int unsigned MAXW = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = '0;
  logic [5:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  logic       IllegalOp, MemTimeout;
  logic [3:0] State;

  mips_multicycle_ctrl #(.MAX_WAIT(MAXW), .ALUCTRL_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .IllegalOp(IllegalOp),
    .MemTimeout(MemTimeout), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic        mr;
    logic        zero;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [16:0] ctl;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   failures = 0;

  // {PCWrite,PCSrc,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,IllegalOp,MemTimeout}
  function automatic logic [16:0] cv(input logic pcw, input logic [1:0] pcs, input logic iord,
      input logic mw, input logic irw, input logic rd, input logic m2r, input logic rw,
      input logic asa, input logic [1:0] asb, input logic [2:0] alu, input logic ill,
      input logic to);
    return {pcw, pcs, iord, mw, irw, rd, m2r, rw, asa, asb, alu, ill, to};
  endfunction

  function automatic logic [16:0] dut_ctl();
    return {PCWrite, PCSrc, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, ALUControl, IllegalOp, MemTimeout};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit op_legal(input logic [5:0] op);
    if (op == 6'b100011 || op == 6'b101011 || op == 6'b000000 || op == 6'b000100 ||
        op == 6'b001000 || op == 6'b000010) return 1'b1;
`ifdef BNE_EN
    if (op == 6'b000101) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] funct, input logic [3:0] st,
                      input logic mr, input logic zero, input logic [16:0] ctl);
    ent_t e;
    e.st = st; e.mr = mr; e.zero = zero; e.op = op; e.funct = funct; e.ctl = ctl;
    q.push_back(e);
  endtask

  // A memory state waiting w cycles on MemReady; gives up after MAXW idle cycles
  task automatic wait_phase(input logic [5:0] op, input logic [5:0] funct, input logic [3:0] st,
      input int w, input logic [16:0] c_wait, input logic [16:0] c_done,
      input logic [16:0] c_to, output bit aborted);
    aborted = 1'b0;
    for (int k = 0; k <= int'(MAXW); k++) begin
      if (k < w) begin
        if (k == int'(MAXW)) begin
          push(op, funct, st, 1'b0, 1'($urandom), c_to);
          aborted = 1'b1;
          return;
        end
        push(op, funct, st, 1'b0, 1'($urandom), c_wait);
      end else begin
        push(op, funct, st, 1'b1, 1'($urandom), c_done);
        return;
      end
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, from fetch to its last state
  task automatic gen(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                     input int fw, input int mw);
    bit ab;
    logic [16:0] f_base, m_rd, m_wr, m_to;
    f_base = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 0, 0);
    wait_phase(op, funct, 4'd0, fw, f_base, f_base | cv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
               f_base | 17'd1, ab);
    if (ab) return;
    push(op, funct, 4'd1, 1'($urandom), 1'($urandom),
         cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, !op_legal(op), 0));
    if (!op_legal(op)) return;
    m_rd = cv(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
    m_wr = cv(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
    m_to = cv(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1);
    case (op)
      6'b100011: begin
        push(op, funct, 4'd2, 1'($urandom), 1'($urandom), cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0, 0));
        wait_phase(op, funct, 4'd3, mw, m_rd, m_rd, m_to, ab);
        if (!ab) push(op, funct, 4'd4, 1'($urandom), 1'($urandom), cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      end
      6'b101011: begin
        push(op, funct, 4'd2, 1'($urandom), 1'($urandom), cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0, 0));
        wait_phase(op, funct, 4'd5, mw, m_wr, m_wr, m_to, ab);
      end
      6'b000000: begin
        push(op, funct, 4'd6, 1'($urandom), 1'($urandom), cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, funct_alu(funct), 0, 0));
        push(op, funct, 4'd7, 1'($urandom), 1'($urandom), cv(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      end
      6'b000100, 6'b000101:
        push(op, funct, 4'd8, 1'($urandom), zero,
             cv(zero ^ (op == 6'b000101), 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 0, 0));
      6'b001000: begin
        push(op, funct, 4'd9, 1'($urandom), 1'($urandom), cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0, 0));
        push(op, funct, 4'd10, 1'($urandom), 1'($urandom), cv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      end
      default:
        push(op, funct, 4'd11, 1'($urandom), 1'($urandom), cv(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endcase
  endtask

  // Called just after a rising edge: apply inputs, sample, advance one cycle
  task automatic drive(input ent_t e, output logic [3:0] st, output logic [16:0] ctl);
    #1;
    reset = 1'b0; Op = e.op; Funct = e.funct; Zero = e.zero; MemReady = e.mr;
    #1;
    st  = State;
    ctl = dut_ctl();
    @(posedge clk);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    MemReady = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1 MemReady = 1'b1;
    #1;
    checks++;
    if (State !== 4'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", State);
    end
    checks++;
    if (dut_ctl() !== cv(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 0, 0)) begin
      failures++; $display("FAIL reset_ctl got=%05h exp=%05h", dut_ctl(), cv(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 0, 0));
    end
    @(posedge clk);
    #1;
    checks++;
    if (State !== 4'd0) begin
      failures++; $display("FAIL reset_hold got=%0d exp=0", State);
    end
    @(posedge clk);
  endtask

  task automatic test_add();
    logic [3:0] st; logic [16:0] ctl;
    do_reset(); q.delete();
    gen(6'b000000, 6'b100000, 1'b0, 0, 0);
    gen(6'b000000, 6'b101010, 1'b0, 1, 0);
    gen(6'b000000, 6'b111111, 1'b0, 0, 0);
    foreach (q[i]) begin
      drive(q[i], st, ctl);
      checks++;
      if ({st, ctl} !== {q[i].st, q[i].ctl}) begin
        failures++; $display("FAIL rtype cyc=%0d state=%0d ctl=%05h exp_state=%0d exp_ctl=%05h", i, st, ctl, q[i].st, q[i].ctl);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] st; logic [16:0] ctl;
    do_reset(); q.delete();
    gen(6'b100011, 6'b000000, 1'b0, 0, 3);
    gen(6'b100011, 6'b000000, 1'b0, 2, int'(MAXW));
    gen(6'b001000, 6'b000000, 1'b0, 0, 0);
    foreach (q[i]) begin
      drive(q[i], st, ctl);
      checks++;
      if ({st, ctl} !== {q[i].st, q[i].ctl}) begin
        failures++; $display("FAIL lw_wait cyc=%0d state=%0d ctl=%05h exp_state=%0d exp_ctl=%05h", i, st, ctl, q[i].st, q[i].ctl);
      end
    end
  endtask

  task automatic test_branch();
    logic [3:0] st; logic [16:0] ctl;
    do_reset(); q.delete();
    gen(6'b000100, 6'b000000, 1'b1, 0, 0);
    gen(6'b000100, 6'b000000, 1'b0, 0, 0);
    gen(6'b000010, 6'b000000, 1'b0, 1, 0);
    foreach (q[i]) begin
      drive(q[i], st, ctl);
      checks++;
      if ({st, ctl} !== {q[i].st, q[i].ctl}) begin
        failures++; $display("FAIL branch cyc=%0d state=%0d ctl=%05h exp_state=%0d exp_ctl=%05h", i, st, ctl, q[i].st, q[i].ctl);
      end
    end
  endtask

  task automatic test_sw_timeout();
    logic [3:0] st; logic [16:0] ctl;
    do_reset(); q.delete();
    gen(6'b101011, 6'b000000, 1'b0, 0, 99);
    gen(6'b101011, 6'b000000, 1'b0, 2, int'(MAXW));
    gen(6'b000010, 6'b000000, 1'b0, 0, 0);
    foreach (q[i]) begin
      drive(q[i], st, ctl);
      checks++;
      if ({st, ctl} !== {q[i].st, q[i].ctl}) begin
        failures++; $display("FAIL sw_timeout cyc=%0d state=%0d ctl=%05h exp_state=%0d exp_ctl=%05h", i, st, ctl, q[i].st, q[i].ctl);
      end
    end
  endtask

  task automatic test_fetch_timeout();
    logic [3:0] st; logic [16:0] ctl;
    do_reset(); q.delete();
    gen(6'b000000, 6'b100010, 1'b0, 99, 0);
    gen(6'b000000, 6'b100010, 1'b0, int'(MAXW), 0);
    foreach (q[i]) begin
      drive(q[i], st, ctl);
      checks++;
      if ({st, ctl} !== {q[i].st, q[i].ctl}) begin
        failures++; $display("FAIL fetch_timeout cyc=%0d state=%0d ctl=%05h exp_state=%0d exp_ctl=%05h", i, st, ctl, q[i].st, q[i].ctl);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] st; logic [16:0] ctl;
    do_reset(); q.delete();
    gen(6'b111111, 6'b000000, 1'b0, 0, 0);
    gen(6'b000101, 6'b000000, 1'b0, 0, 0);
    gen(6'b000101, 6'b000000, 1'b1, 0, 0);
    gen(6'b000011, 6'b000000, 1'b0, 1, 0);
    foreach (q[i]) begin
      drive(q[i], st, ctl);
      checks++;
      if ({st, ctl} !== {q[i].st, q[i].ctl}) begin
        failures++; $display("FAIL illegal cyc=%0d state=%0d ctl=%05h exp_state=%0d exp_ctl=%05h", i, st, ctl, q[i].st, q[i].ctl);
      end
    end
  endtask

  task automatic test_reset_midwait();
    logic [3:0] st; logic [16:0] ctl;
    do_reset(); q.delete();
    gen(6'b100011, 6'b000000, 1'b0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      drive(q[i], st, ctl);
      checks++;
      if ({st, ctl} !== {q[i].st, q[i].ctl}) begin
        failures++; $display("FAIL midwait_pre cyc=%0d state=%0d ctl=%05h exp_state=%0d exp_ctl=%05h", i, st, ctl, q[i].st, q[i].ctl);
      end
    end
    #1 reset = 1'b1;
    @(posedge clk);
    q.delete();
    gen(6'b100011, 6'b000000, 1'b0, int'(MAXW), 99);
    for (int i = 0; i < int'(MAXW) + 5; i++) begin
      drive(q[i], st, ctl);
      checks++;
      if ({st, ctl} !== {q[i].st, q[i].ctl}) begin
        failures++; $display("FAIL midwait_post cyc=%0d state=%0d ctl=%05h exp_state=%0d exp_ctl=%05h", i, st, ctl, q[i].st, q[i].ctl);
      end
    end
    #1 reset = 1'b1; MemReady = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({State, MemTimeout} !== {4'd0, 1'b0}) begin
      failures++; $display("FAIL midwait_reset state=%0d to=%0b exp_state=0 exp_to=0", State, MemTimeout);
    end
  endtask

  task automatic test_random();
    logic [3:0] st; logic [16:0] ctl;
    logic [5:0] ops[10];
    logic [5:0] fns[6];
    logic [5:0] op;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010,
            6'b000101, 6'b111111, 6'b000000, 6'b100011};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    do_reset(); q.delete();
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      gen(op, fns[$urandom_range(0, 5)], 1'($urandom),
          ($urandom_range(0, 7) == 0) ? int'(MAXW) + 1 : int'($urandom_range(0, 2)),
          int'($urandom_range(0, MAXW + 1)));
    end
    foreach (q[i]) begin
      drive(q[i], st, ctl);
      checks++;
      if ({st, ctl} !== {q[i].st, q[i].ctl}) begin
        failures++; $display("FAIL random cyc=%0d op=%b state=%0d ctl=%05h exp_state=%0d exp_ctl=%05h", i, q[i].op, st, ctl, q[i].st, q[i].ctl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_sw_timeout();
    test_fetch_timeout();
    test_illegal();
    test_reset_midwait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM for the 32-bit multicycle MIPS datapath; replaces hand-driven control-signal stimulus with decoding of Op/Funct.
- Sits beside DataPath: consumes Op, Funct, Zero and memory MemReady; drives every datapath control input.
- Generalised over the previous control scheme: 2-bit PCSrc (adds jump), memory wait-state handshake with watchdog, addi and j support, parametrised wait limit.

Parameters:
- MAX_WAIT, 15, max cycles a memory state waits for MemReady before timeout (1..255).
- ALUCTRL_WIDTH, 3, ALUControl width; must be >= 3, upper bits driven 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; FSM to FETCH, watchdog cleared.
- Op  in  6  instruction opcode (IR[31:26]).
- Funct  in  6  function field (IR[5:0]).
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC enable; includes the branch-taken term.
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- IorD  out  1  0 PC address, 1 ALUOut address.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  0 rt, 1 rd.
- MemtoReg  out  1  0 ALUOut, 1 memory data.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 PC, 1 A.
- ALUSrcB  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2.
- ALUControl  out  ALUCTRL_WIDTH  ALU operation.
- IllegalOp  out  1  one-cycle pulse on unknown opcode.
- MemTimeout  out  1  one-cycle pulse on watchdog expiry.
- State  out  4  current state code (debug).

Behaviour:
- States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11; codes 12-15 unreachable and go to FETCH.
- Reset: State=FETCH, watchdog=0, IllegalOp=0, MemTimeout=0. Outputs are then the FETCH decode with MemReady gating; all other controls 0.
- Unlisted outputs are 0 in each state.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALU add, PCSrc=00. IRWrite=PCWrite=MemReady. Leaves to DECODE only when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU add. Next state by Op:
  - 100011 lw and 101011 sw -> MEMADR.
  - 000000 -> EXECUTE.
  - 000100 -> BRANCH.
  - 001000 -> ADDIEXEC.
  - 000010 -> JUMP.
  - Any other Op -> FETCH, with IllegalOp pulsed in the DECODE cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALU add. lw -> MEMREAD, sw -> MEMWRITE (Op held stable by IR).
- MEMREAD: IorD=1. Waits for MemReady, then -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWRITE: IorD=1, MemWrite=1 held until MemReady, then -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALU from Funct -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU sub, PCSrc=01, PCWrite=Zero -> FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALU add -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- ALUControl encoding: add 010, sub 110. Funct decode: 100000 add 010, 100010 sub 110, 100100 and 000, 100101 or 001, 101010 slt 111. Unknown Funct gives 010 and no IllegalOp.
- Watchdog (FETCH, MEMREAD, MEMWRITE):
  - Counts the cycles spent in the state with MemReady=0; clears on state change.
  - When the count reaches MAX_WAIT with MemReady still 0, MemTimeout pulses for 1 cycle and next state = FETCH.
  - No IRWrite, PCWrite, MemWrite or RegWrite is asserted in the expiry cycle. FETCH timeout re-enters FETCH, i.e. a retry.
  - MemReady=1 in the expiry cycle takes priority: normal transition, no timeout.
- Reset asserted in any state, including mid-wait, takes effect next edge; it overrides all transitions.

Optional Feature:
- Macro BNE_EN.
- Defined: Op 000101 decodes to BRANCH. A bne flag is registered in DECODE, and in BRANCH PCWrite = Zero XOR bne.
- Undefined: 000101 is illegal; it pulses IllegalOp and returns to FETCH.

Test Plan:
- reset=1 for 2 cycles, MemReady=1 -> State=0, IRWrite=1, PCWrite=1, ALUSrcB=01, ALUControl=010.
- add R-type (Op=0, Funct=100000), MemReady=1 -> states 0,1,6,7,0; RegDst=1 and RegWrite=1 only in state 7.
- lw with MemReady low 3 cycles in MEMREAD -> State stays 3 for 3 cycles, then 4 with MemtoReg=1, RegWrite=1.
- beq, Zero=1 -> in state 8, PCWrite=1, PCSrc=01, ALUControl=110. Repeat with Zero=0 -> PCWrite=0.
- MAX_WAIT=4, sw with MemReady held 0 -> MemWrite=1 for 4 cycles, MemTimeout pulses once, State=0, no further MemWrite.
- Op=111111 -> IllegalOp=1 for one cycle in DECODE, State returns 0. With BNE_EN, Op=000101, Zero=0 -> PCWrite=1 in state 8.
